// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer helpers.
// Used by read-side (and write-side) pointer logic.
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 4;
  localparam int GW = 32;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic int ptr_w(input int addrsize);
    return addrsize + 1;
  endfunction

  // Operate on a wide zero-extended word;
  // callers truncate to their pointer width.
  function automatic logic [GW-1:0] bin2gray(
    input logic [GW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  typedef enum logic [1:0] {
    SK_IDLE = 2'b00,
    SK_POP  = 2'b01,
    SK_PUSH = 2'b10,
    SK_BOTH = 2'b11
  } skid_op_e;

endpackage

// File: rtl/fifo_fwft_reader_skid.sv
// fifo_out_skid: 2-entry FWFT output buffer.
// Ports: i_clk, i_rst_n (sync, low), i_push/i_data
// (tail fill), i_ready (consumer), o_dout/o_valid
// (head), o_pop (head accepted), o_count (0..2).
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [DATASIZE-1:0] i_data,
  input  logic                i_ready,
  output logic [DATASIZE-1:0] o_dout,
  output logic                o_valid,
  output logic                o_pop,
  output logic [1:0]          o_count
);

  logic [DATASIZE-1:0] r_head;
  logic [DATASIZE-1:0] r_tail;
  logic [1:0]          r_count;
  logic                r_valid;

  logic [DATASIZE-1:0] w_head_nxt;
  logic [DATASIZE-1:0] w_tail_nxt;
  logic [1:0]          w_count_nxt;
  skid_op_e            w_op;

  assign o_pop   = r_valid && i_ready;
  assign o_dout  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_op        = skid_op_e'({i_push, o_pop});
    unique case (w_op)
      SK_POP: begin
        w_head_nxt  = r_tail;
        w_count_nxt = r_count - 2'd1;
      end
      SK_PUSH: begin
        if (r_count == 2'd0) w_head_nxt = i_data;
        else                 w_tail_nxt = i_data;
        w_count_nxt = r_count + 2'd1;
      end
      SK_BOTH: begin
        // With one entry the new word lands
        // straight in the head slot.
        if (r_count == 2'd1) begin
          w_head_nxt = i_data;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = i_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/fifo_fwft_reader.sv
// FIFO read-side controller: read pointer, FWFT out.
// Ports: rclk, rrst_n (sync, low), rwptr (synced),
// raddr/rdata (memory), dout/dout_valid/dout_ready,
// rptr/rgray, rempty, rlevel, rerr (sticky overrun).
module fifo_fwft_reader
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rwptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rgray,
  output logic                rempty,
  output logic [ADDRSIZE+1:0] rlevel,
  output logic                rerr
);

  localparam int PW    = ptr_w(ADDRSIZE);
  localparam int DEPTH = depth_of(ADDRSIZE);
  localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);

  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rgray;
  logic          r_rerr;

  logic [PW-1:0] w_rptr_nxt;
  logic [PW-1:0] w_diff;
  logic          w_rempty;
  logic          w_fetch;
  logic          w_pop;
  logic [1:0]    w_count;

  assign w_rempty   = (rwptr == r_rptr);
  assign w_fetch    = !w_rempty &&
                      ((w_count != 2'd2) || w_pop);
  assign w_rptr_nxt = r_rptr + PW'(1);
  // Modulo distance; wraps with the extra MSB.
  assign w_diff     = rwptr - r_rptr;

  assign raddr  = r_rptr[ADDRSIZE-1:0];
  assign rptr   = r_rptr;
  assign rgray  = r_rgray;
  assign rerr   = r_rerr;
  assign rempty = w_rempty;
  assign rlevel = {1'b0, w_diff} +
                  {{(PW-1){1'b0}}, w_count};

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_rptr  <= '0;
      r_rgray <= '0;
      r_rerr  <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_rptr  <= w_rptr_nxt;
        r_rgray <= PW'(bin2gray(GW'(w_rptr_nxt)));
      end
      if ({1'b0, w_diff} > DEPTH_V) r_rerr <= 1'b1;
    end
  end

  fifo_out_skid #(
    .DATASIZE (DATASIZE)
  ) u_skid (
    .i_clk   (rclk),
    .i_rst_n (rrst_n),
    .i_push  (w_fetch),
    .i_data  (rdata),
    .i_ready (dout_ready),
    .o_dout  (dout),
    .o_valid (dout_valid),
    .o_pop   (w_pop),
    .o_count (w_count)
  );

endmodule

// File: doc/fifo_fwft_reader.md
Name: fifo_fwft_reader

Overview:
- Single-clock read-side controller for the FIFO dual-port memory.
- Owns the read pointer and drives the memory read address.
- Consumes the memory's asynchronous read data.
- Presents a first-word-fall-through valid/ready stream through a 2-entry output buffer.
- Exports binary and Gray read pointers for the write domain's full logic.

Parameters:
- DATASIZE, 8, memory data word width.
- ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE.

Ports:
- rclk  input  1  read clock; all state updates on posedge.
- rrst_n  input  1  synchronous, active-low reset, sampled on posedge rclk.
- rwptr  input  ADDRSIZE+1  write pointer (binary), already synchronised into rclk domain.
- raddr  output  ADDRSIZE  memory read address = rptr[ADDRSIZE-1:0].
- rdata  input  DATASIZE  memory read data, combinational function of raddr.
- dout  output  DATASIZE  head word of output buffer.
- dout_valid  output  1  head word present.
- dout_ready  input  1  consumer accepts head this cycle.
- rptr  output  ADDRSIZE+1  binary read pointer.
- rgray  output  ADDRSIZE+1  Gray-coded read pointer, registered.
- rempty  output  1  memory holds no unfetched words (rwptr == rptr).
- rlevel  output  ADDRSIZE+2  unfetched words (rwptr-rptr, modulo) plus buffer occupancy.
- rerr  output  1  sticky: rwptr-rptr exceeded DEPTH.

Behaviour:
- Reset (rrst_n low at posedge): rptr=0, rgray=0, buffer count=0, dout=0, dout_valid=0, rerr=0. Reset mid-stream discards buffered words; rwptr is not touched.
- Per-cycle definitions:
  - pop = dout_valid && dout_ready.
  - rempty = (rwptr == rptr), combinational.
  - fetch = !rempty && (count<2 || pop).
- Fetch:
  - Captures rdata (addressed by the current raddr) into the buffer tail.
  - Increments rptr by 1; wraps naturally at 2^(ADDRSIZE+1).
  - rgray <= next_rptr ^ (next_rptr>>1).
- Buffer: 2-entry FIFO; dout is the registered head entry.
  - pop only: entry1 moves to head; count-1.
  - fetch only: fills the first free slot; count+1.
  - fetch+pop: head advances and the new word fills the tail; count unchanged. If count==1, the new word becomes head directly.
  - dout_valid = (count != 0), registered.
  - dout holds its last value when count==0. Its value is don't-care; the bench must not check it.
- Latency: a word visible in memory at cycle N (rwptr advanced) appears on dout with dout_valid at cycle N+1. Sustained throughput is 1 word/cycle with dout_ready held high.
- Back-pressure: with dout_ready low, at most 2 words leave memory; rptr stalls; the remainder stays counted in rlevel.
- Ordering: strict FIFO order; no word duplicated or dropped across any combination of fetch, pop and stall.
- rlevel = (rwptr - rptr) mod 2^(ADDRSIZE+1), zero-extended, + count; combinational.
- rerr: set when (rwptr - rptr) mod 2^(ADDRSIZE+1) > DEPTH. Cleared only by reset. Does not alter data flow.
- rempty with dout_valid high is legal: the memory is drained but the buffer is not.

Decomposition:
- Package fifo_pkg:
  - DEPTH derivation.
  - bin2gray function, shared with the write-side pointer logic.
  - Pointer width constant ADDRSIZE+1.
- One sub-module: fifo_out_skid. It holds the 2-entry buffer, count, push/pop and head/valid generation, parameterised by DATASIZE. The pointer, empty, level and rerr logic stays in the top.

Test Plan:
- Reset then idle, rwptr=0 -> rempty=1, dout_valid=0, rptr=0, rgray=0, rlevel=0 for 10 cycles.
- Memory preloaded 0xA0..0xA3, rwptr steps to 4 at cycle 0, dout_ready=1 -> dout_valid from cycle 1. dout=0xA0,0xA1,0xA2,0xA3 on consecutive cycles. rptr=4 and rempty=1 after the 4th fetch. rgray=6 after the last fetch.
- rwptr=5 with dout_ready=0 -> after 2 cycles rptr=2, count=2, rlevel=5. Assert dout_ready for one cycle -> exactly one pop, rptr=3, rlevel=4.
- Wrap test, ADDRSIZE=4, rptr starts at 30, rwptr=2 (4 words) -> reads addresses 14,15,0,1. rptr ends at 2. rgray sequence 17,16,0,1,3 holds at each step. rerr stays 0.
- rwptr jumps from 0 to 17 -> rerr=1 next cycle and remains 1 until rrst_n low.
- Reset asserted while count=2 and rempty=0 -> next cycle dout_valid=0, rptr=0, rlevel equals rwptr.
